// File: rtl/c17v4_bist_array.sv
// c17v4_bist_array: self-testing, pipelined array of C17V4 lanes.
// An LFSR feeds every lane, a MISR compacts the lane outputs, and the
// final signature is compared against a supplied golden value. One lane
// can have its internal node w1 stuck at 1 for fault-coverage runs.
module c17v4_bist_array #(
    parameter int          LANES    = 4,
    parameter int          PATTERNS = 256,
    parameter logic [31:0] SEED     = 32'hACE1_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          golden,
    input  logic                 fault_en,
    input  logic [2:0]           fault_lane,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [31:0]          signature,
    output logic [5*LANES-1:0]   lane_in_q,
    output logic [2*LANES-1:0]   lane_out_q
);

    // Wide enough to hold PATTERNS so the run counter never wraps mid-run.
    localparam int CW = $clog2(PATTERNS + 1);

    if (LANES < 1 || LANES > 6) begin : gBadLanes
        $error("c17v4_bist_array: LANES must be in 1..6");
    end
    if (PATTERNS < 1) begin : gBadPatterns
        $error("c17v4_bist_array: PATTERNS must be at least 1");
    end
    if (SEED == 32'h0) begin : gBadSeed
        $error("c17v4_bist_array: SEED must be non-zero");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [31:0]         lfsr_q;
    logic [31:0]         misr_q;
    logic [CW-1:0]       cnt_q;
    logic                v1_q, v2_q;
    logic                faultEn_q;
    logic [2:0]          faultLane_q;

    logic                issue;
    logic                beginRun;
    logic [31:0]         lfsrNext;
    logic [31:0]         misrNext;
    logic [5*LANES-1:0]  laneIn_d;
    logic [2*LANES-1:0]  laneOut_d;
    logic [LANES-1:0]    w1;

    // LFSR advance and MISR compaction share the same feedback taps.
    always_comb begin
        lfsrNext = {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
        misrNext = {misr_q[30:0], misr_q[31] ^ misr_q[21] ^ misr_q[1] ^ misr_q[0]}
                   ^ 32'(lane_out_q);
    end

    // Slice the LFSR into per-lane {G5,G4,G3,G2,G1} input groups.
    always_comb begin
        laneIn_d = '0;
        for (int k = 0; k < LANES; k++) begin
            for (int j = 0; j < 5; j++) begin
                laneIn_d[5*k+j] = lfsr_q[(5*k+j) % 32];
            end
        end
    end

    // C17V4 function per lane; the selected faulty lane sees w1 forced high.
    always_comb begin
        w1        = '0;
        laneOut_d = '0;
        for (int k = 0; k < LANES; k++) begin
            w1[k] = (lane_in_q[5*k+4] & lane_in_q[5*k+1])
                    | (faultEn_q && (faultLane_q == 3'(k)));
            laneOut_d[2*k]   = (lane_in_q[5*k+4] & lane_in_q[5*k])
                               | (lane_in_q[5*k+3] & ~w1[k]);
            laneOut_d[2*k+1] = (lane_in_q[5*k+3] | lane_in_q[5*k+2]) & ~w1[k];
        end
    end

    // Sequencer next-state and status outputs; FLUSH ends once stage 1 is empty.
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        beginRun = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    beginRun = 1'b1;
                end
            end
            RUN: begin
                busy  = 1'b1;
                issue = 1'b1;
                if (cnt_q == CW'(PATTERNS - 1)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                busy = 1'b1;
                if (!v1_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        pass = done && (misr_q == golden);
    end

    // State, pipeline and signature registers; reset aborts any run immediately.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            lfsr_q      <= SEED;
            misr_q      <= '0;
            cnt_q       <= '0;
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            faultEn_q   <= 1'b0;
            faultLane_q <= '0;
            lane_in_q   <= '0;
            lane_out_q  <= '0;
        end else begin
            state_q <= state_d;
            v1_q    <= issue;
            v2_q    <= v1_q;
            if (issue) begin
                lane_in_q <= laneIn_d;
            end
            if (v1_q) begin
                lane_out_q <= laneOut_d;
            end
            if (beginRun) begin
                lfsr_q      <= SEED;
                misr_q      <= '0;
                cnt_q       <= '0;
                faultEn_q   <= fault_en;
                faultLane_q <= fault_lane;
            end else begin
                if (issue) begin
                    lfsr_q <= lfsrNext;
                    cnt_q  <= cnt_q + CW'(1);
                end
                if (v2_q) begin
                    misr_q <= misrNext;
                end
            end
        end
    end

    assign signature = misr_q;

endmodule

// File: tb/tb_c17v4_bist_array.sv
// tb_c17v4_bist_array: directed checks of the C17V4 BIST array.
// Two single-pattern instances exercise lane function, timing and fault
// injection with hand-computed values; a full-size instance is compared
// against a reference signature computed here.
module tb_c17v4_bist_array;

    localparam logic [31:0] SEED_M = 32'hACE1_0001;

    logic clk;
    logic rst;

    // Full-size instance (4 lanes, 256 patterns)
    logic        startM, faultEnM, busyM, doneM, passM;
    logic [2:0]  faultLaneM;
    logic [31:0] goldenM, sigM;
    logic [19:0] laneInM;
    logic [7:0]  laneOutM;

    // Instance A: lane0 = 11001, lane1 = 11110
    logic        startA, faultEnA, busyA, doneA, passA;
    logic [2:0]  faultLaneA;
    logic [31:0] goldenA, sigA;
    logic [9:0]  laneInA;
    logic [3:0]  laneOutA;

    // Instance B: lane0 = lane1 = 01100
    logic        startB, faultEnB, busyB, doneB, passB;
    logic [2:0]  faultLaneB;
    logic [31:0] goldenB, sigB;
    logic [9:0]  laneInB;
    logic [3:0]  laneOutB;

    int checkCount;
    int errorCount;
    logic [31:0] modelSig;

    c17v4_bist_array #(.LANES(4), .PATTERNS(256), .SEED(SEED_M)) dutM (
        .clk(clk), .rst(rst), .start(startM), .golden(goldenM),
        .fault_en(faultEnM), .fault_lane(faultLaneM),
        .busy(busyM), .done(doneM), .pass(passM), .signature(sigM),
        .lane_in_q(laneInM), .lane_out_q(laneOutM)
    );

    c17v4_bist_array #(.LANES(2), .PATTERNS(1), .SEED(32'h0000_03D9)) dutA (
        .clk(clk), .rst(rst), .start(startA), .golden(goldenA),
        .fault_en(faultEnA), .fault_lane(faultLaneA),
        .busy(busyA), .done(doneA), .pass(passA), .signature(sigA),
        .lane_in_q(laneInA), .lane_out_q(laneOutA)
    );

    c17v4_bist_array #(.LANES(2), .PATTERNS(1), .SEED(32'h0000_018C)) dutB (
        .clk(clk), .rst(rst), .start(startB), .golden(goldenB),
        .fault_en(faultEnB), .fault_lane(faultLaneB),
        .busy(busyB), .done(doneB), .pass(passB), .signature(sigB),
        .lane_in_q(laneInB), .lane_out_q(laneOutB)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: count it and report any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Reference C17V4 lane: g = {G5,G4,G3,G2,G1}, returns {G7,G6}.
    function automatic logic [1:0] c17Ref(input logic [4:0] g);
        logic nand52;
        logic g6, g7;
        nand52 = ~(g[4] & g[1]);
        g6 = (g[4] & g[0]) | (g[3] & nand52);
        g7 = (g[3] | g[2]) & nand52;
        return {g7, g6};
    endfunction

    // Reference signature for the 4-lane, 256-pattern instance.
    function automatic logic [31:0] refSignature();
        logic [31:0] lfsr, misr;
        logic [7:0]  outs;
        lfsr = SEED_M;
        misr = 32'h0;
        for (int p = 0; p < 256; p++) begin
            outs = '0;
            for (int k = 0; k < 4; k++) begin
                outs[2*k +: 2] = c17Ref(lfsr[5*k +: 5]);
            end
            lfsr = {lfsr[30:0], lfsr[31] ^ lfsr[21] ^ lfsr[1] ^ lfsr[0]};
            misr = {misr[30:0], misr[31] ^ misr[21] ^ misr[1] ^ misr[0]} ^ {24'h0, outs};
        end
        return misr;
    endfunction

    // One single-pattern run on instance B with a given fault setting.
    task automatic applyStimulus(input string tag, input logic en, input logic [2:0] lane,
                                 input logic [3:0] expOut, input logic expPass);
        goldenB    = 32'h0000_000F;
        faultEnB   = en;
        faultLaneB = lane;
        startB     = 1'b1;
        tick();
        startB   = 1'b0;
        faultEnB = 1'b0;
        faultLaneB = 3'd0;
        tick();
        tick();
        checkOutput({tag, "_laneOut"}, 32'(laneOutB), 32'(expOut));
        tick();
        checkOutput({tag, "_done"}, 32'(doneB), 32'd1);
        checkOutput({tag, "_sig"}, sigB, 32'(expOut));
        checkOutput({tag, "_pass"}, 32'(passB), 32'(expPass));
        tick();
    endtask

    // Full run on the large instance; optionally pokes start while busy and in DONE.
    task automatic runMain(input string tag, input logic [31:0] gold, input logic expPass,
                           input bit disturb);
        int cycles;
        goldenM = gold;
        startM  = 1'b1;
        tick();
        startM = 1'b0;
        checkOutput({tag, "_firstBusy"}, 32'(busyM), 32'd1);
        cycles = 0;
        while (busyM && cycles < 400) begin
            cycles++;
            startM = disturb && (cycles == 5 || cycles == 257 || cycles == 258);
            tick();
        end
        startM = 1'b0;
        checkOutput({tag, "_busyCycles"}, 32'(cycles), 32'd258);
        checkOutput({tag, "_done"}, 32'(doneM), 32'd1);
        checkOutput({tag, "_pass"}, 32'(passM), 32'(expPass));
        checkOutput({tag, "_sig"}, sigM, modelSig);
        startM = disturb;
        tick();
        startM = 1'b0;
        checkOutput({tag, "_doneAfter"}, 32'(doneM), 32'd0);
        checkOutput({tag, "_idleAfter"}, 32'(busyM), 32'd0);
        checkOutput({tag, "_sigHeld"}, sigM, modelSig);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int sawDone;
        checkCount = 0;
        errorCount = 0;
        rst = 1'b1;
        startM = 1'b0; faultEnM = 1'b0; faultLaneM = 3'd0; goldenM = 32'h0;
        startA = 1'b0; faultEnA = 1'b0; faultLaneA = 3'd0; goldenA = 32'h0000_0003;
        startB = 1'b0; faultEnB = 1'b0; faultLaneB = 3'd0; goldenB = 32'h0000_000F;
        modelSig = refSignature();
        $display("[TB] reference signature 0x%08h", modelSig);

        repeat (3) tick();
        checkOutput("rst_busy", 32'(busyM), 32'd0);
        checkOutput("rst_done", 32'(doneM), 32'd0);
        checkOutput("rst_pass", 32'(passM), 32'd0);
        checkOutput("rst_sig", sigM, 32'h0);
        checkOutput("rst_laneIn", 32'(laneInM), 32'h0);
        checkOutput("rst_laneOut", 32'(laneOutM), 32'h0);
        rst = 1'b0;
        tick();
        checkOutput("idle_busy", 32'(busyM), 32'd0);

        // Single-pattern timing and lane function on A and B together
        startA = 1'b1;
        startB = 1'b1;
        tick();
        startA = 1'b0;
        startB = 1'b0;
        checkOutput("t1_busyA", 32'(busyA), 32'd1);
        tick();
        checkOutput("t1_laneInA", 32'(laneInA), 32'h3D9);
        checkOutput("t2_laneInB", 32'(laneInB), 32'h18C);
        tick();
        checkOutput("t1_laneOutA", 32'(laneOutA), 32'h3);
        checkOutput("t2_laneOutB", 32'(laneOutB), 32'hF);
        checkOutput("t1_doneEarly", 32'(doneA), 32'd0);
        tick();
        checkOutput("t1_doneA", 32'(doneA), 32'd1);
        checkOutput("t1_busyDoneA", 32'(busyA), 32'd0);
        checkOutput("t1_sigA", sigA, 32'h3);
        checkOutput("t1_passA", 32'(passA), 32'd1);
        checkOutput("t2_doneB", 32'(doneB), 32'd1);
        checkOutput("t2_sigB", sigB, 32'hF);
        checkOutput("t2_passB", 32'(passB), 32'd1);
        checkOutput("t2_busyB", 32'(busyB), 32'd0);
        tick();
        checkOutput("t1_donePulseA", 32'(doneA), 32'd0);
        checkOutput("t1_passLowA", 32'(passA), 32'd0);
        checkOutput("t1_sigHeldA", sigA, 32'h3);

        // Fault injection on B: lane 0 faulty, then an out-of-range lane
        applyStimulus("t3_fault0", 1'b1, 3'd0, 4'b1100, 1'b0);
        applyStimulus("t3_fault1", 1'b1, 3'd1, 4'b0011, 1'b0);
        applyStimulus("t3_laneOOR", 1'b1, 3'd2, 4'b1111, 1'b1);
        applyStimulus("t3_noFault", 1'b0, 3'd0, 4'b1111, 1'b1);

        // Full run: first output pattern, then pass and mismatching golden
        goldenM = modelSig;
        startM = 1'b1;
        tick();
        startM = 1'b0;
        tick();
        checkOutput("t4_firstLaneIn", 32'(laneInM), 32'h10001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        runMain("t4_pass", modelSig, 1'b1, 1'b0);
        runMain("t4_badGolden", modelSig ^ 32'h1, 1'b0, 1'b0);

        // Abort mid-run with reset
        goldenM = modelSig;
        startM = 1'b1;
        tick();
        startM = 1'b0;
        repeat (10) tick();
        checkOutput("t5_midBusy", 32'(busyM), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t5_busy", 32'(busyM), 32'd0);
        checkOutput("t5_sig", sigM, 32'h0);
        checkOutput("t5_laneIn", 32'(laneInM), 32'h0);
        sawDone = 0;
        for (int i = 0; i < 5; i++) begin
            if (doneM) sawDone++;
            tick();
        end
        checkOutput("t5_noDone", 32'(sawDone), 32'd0);
        runMain("t5_rerun", modelSig, 1'b1, 1'b0);

        // Starts while busy or in DONE are ignored
        runMain("t6_disturb", modelSig, 1'b1, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
